fetch_unit_buffered: RTL

//  Next-generation IF stage of the pipelined ARM core. Replaces the fixed-width

---
 rtl/fetch_unit_buffered_if.sv | 41 ++++
 rtl/fetch_unit_buffered.sv | 115 +++++++++++
 2 files changed

// File: rtl/fetch_unit_buffered_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_buffered_if
//  Brief    : Redirect, instruction-memory and decode handshake bundle for
//             the buffered fetch unit.
//  Revision : 1.0
// ============================================================================
interface fetch_unit_buffered_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_target;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;
    logic [ADDR_W-1:0]  if_pc_plus4;

    modport master (
        input  redirect_valid, redirect_target,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output if_valid, if_instr, if_pc, if_pc_plus4,
        input  if_ready
    );

    modport slave (
        output redirect_valid, redirect_target,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  if_valid, if_instr, if_pc, if_pc_plus4,
        output if_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_buffered
//  Brief    : IF stage with PC, credit-limited imem requests, in-order tag
//             queue and DEPTH-entry prefetch FIFO with redirect flush.
//  Revision : 1.0
// ============================================================================
module fetch_unit_buffered #(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  wire logic               clk,
    input  wire logic               reset,
    fetch_unit_buffered_if.master   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0]   c_DEPTH = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] c_LAST  = PW'(DEPTH - 1);

    logic [ADDR_W-1:0]  r_pc;
    logic [CW-1:0]      r_out;
    logic [CW-1:0]      r_drop;
    logic [CW-1:0]      r_cnt;
    logic [PW-1:0]      r_tag_wp, r_tag_rp;
    logic [PW-1:0]      r_ff_wp,  r_ff_rp;
    logic [ADDR_W-1:0]  r_tag_mem  [DEPTH];
    logic [INSTR_W-1:0] r_ff_instr [DEPTH];
    logic [ADDR_W-1:0]  r_ff_pc    [DEPTH];

    logic               w_redir, w_credit, w_req_valid, w_req_fire;
    logic               w_rsp, w_push, w_empty, w_if_valid, w_pop;
    logic [CW-1:0]      w_out_dec, w_out_nxt;
    logic [ADDR_W-1:0]  w_head_pc;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    // FIFO occupancy plus in-flight requests never exceeds DEPTH, so a kept
    // response always finds a free FIFO slot.
    assign w_redir     = bus.redirect_valid;
    assign w_credit    = ({1'b0, r_cnt} + {1'b0, r_out}) < c_DEPTH;
    assign w_req_valid = !reset && !w_redir && w_credit;
    assign w_req_fire  = w_req_valid && bus.imem_req_ready;
    assign w_rsp       = bus.imem_rsp_valid;
    assign w_push      = w_rsp && (r_drop == '0) && !w_redir;
    assign w_empty     = (r_cnt == '0);
    assign w_if_valid  = !w_empty && !w_redir;
    assign w_pop       = w_if_valid && bus.if_ready;
    assign w_out_dec   = r_out - CW'(w_rsp);
    assign w_out_nxt   = w_out_dec + CW'(w_req_fire);
    assign w_head_pc   = w_empty ? '0 : r_ff_pc[r_ff_rp];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_out    <= '0;
            r_drop   <= '0;
            r_cnt    <= '0;
            r_tag_wp <= '0;
            r_tag_rp <= '0;
            r_ff_wp  <= '0;
            r_ff_rp  <= '0;
        end else begin
            r_out <= w_out_nxt;
            if (w_req_fire) begin
                r_pc     <= r_pc + ADDR_W'(4);
                r_tag_wp <= f_inc(r_tag_wp);
            end
            if (w_rsp)
                r_tag_rp <= f_inc(r_tag_rp);
            if (w_redir) begin
                // Everything still in flight belongs to the old path.
                r_pc    <= bus.redirect_target;
                r_drop  <= w_out_dec;
                r_cnt   <= '0;
                r_ff_wp <= '0;
                r_ff_rp <= '0;
            end else begin
                if (w_rsp && (r_drop != '0))
                    r_drop <= r_drop - 1'b1;
                if (w_push)
                    r_ff_wp <= f_inc(r_ff_wp);
                if (w_pop)
                    r_ff_rp <= f_inc(r_ff_rp);
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_req_fire)
            r_tag_mem[r_tag_wp] <= r_pc;
        if (w_push) begin
            r_ff_instr[r_ff_wp] <= bus.imem_rsp_data;
            r_ff_pc[r_ff_wp]    <= r_tag_mem[r_tag_rp];
        end
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.if_valid       = w_if_valid;
    assign bus.if_instr       = w_empty ? '0 : r_ff_instr[r_ff_rp];
    assign bus.if_pc          = w_head_pc;
    assign bus.if_pc_plus4    = w_empty ? '0 : w_head_pc + ADDR_W'(4);

    ap_rsp_has_tag: assert property (@(posedge clk) disable iff (reset)
        w_rsp |-> (r_out != '0));
    ap_no_overflow: assert property (@(posedge clk) disable iff (reset)
        w_push |-> (r_cnt != CW'(DEPTH)));
endmodule
`default_nettype wire
